aes_sbox_array: RTL and testbench

//  Parametrised, pipelined AES byte-substitution engine: LANES independent S-box lookups per beat,

---
 rtl/aes_sbox_array.sv | 170 +++++++++++++++++
 tb/tb_aes_sbox_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_array.sv
// aes_sbox_array: LANES parallel AES S-box lookups feeding a STAGES-deep valid/ready pipeline.
// Define AES_SBOX_INV_EN to add the per-beat inverse S-box (In_inv selects S^-1).
module aes_sbox_array #(
    parameter int LANES  = 16,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          in_inv_i,
    input  logic [8*LANES-1:0]            in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_inv_o,
    output logic [8*LANES-1:0]            out_data_o,
    output logic [$clog2(STAGES+1)-1:0]   occupancy_o
);
    localparam int W  = 8 * LANES;
    localparam int OW = $clog2(STAGES + 1);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] s;
        b = gf_inv(a);
        s = 8'h00;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
        return s ^ 8'h63;
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
        return gf_inv(b ^ 8'h05);
    endfunction
`endif

    logic [W-1:0] lookup;
    logic         inv_sel;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef AES_SBOX_INV_EN
        assign lookup[8*gi +: 8] = in_inv_i ? sbox_inv(in_data_i[8*gi +: 8])
                                            : sbox_fwd(in_data_i[8*gi +: 8]);
`else
        assign lookup[8*gi +: 8] = sbox_fwd(in_data_i[8*gi +: 8]);
`endif
    end

`ifdef AES_SBOX_INV_EN
    assign inv_sel = in_inv_i;
`else
    logic unused_inv;
    assign unused_inv = in_inv_i;
    assign inv_sel    = 1'b0;
`endif

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] stage_ready, down_ready, fill;
    logic [OW-1:0]     occ_q, occ_d;
    logic [W-1:0]      stage_data [STAGES];
    logic              stage_inv  [STAGES];
    logic              bub;

    // Ready of a stage = output ready or any bubble downstream; flat form avoids a comb chain
    always_comb begin
        stage_ready = '0;
        down_ready  = '0;
        fill        = '0;
        valid_d     = valid_q;
        bub         = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            bub = 1'b0;
            for (int j = k + 1; j < STAGES; j++) bub = bub | ~valid_q[j];
            down_ready[k]  = out_ready_i | bub;
            stage_ready[k] = ~valid_q[k] | down_ready[k];
        end
        fill[0] = in_valid_i & stage_ready[0];
        for (int k = 1; k < STAGES; k++) fill[k] = valid_q[k-1] & stage_ready[k];
        for (int k = 0; k < STAGES; k++) valid_d[k] = fill[k] | (valid_q[k] & ~down_ready[k]);
    end

    always_comb begin
        occ_d = occ_q;
        if (fill[0] && !(valid_q[STAGES-1] && out_ready_i))
            occ_d = occ_q + OW'(1);
        else if (!fill[0] && valid_q[STAGES-1] && out_ready_i)
            occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [W-1:0] data_d, data_q;
        logic         inv_d, inv_q;
        if (gi == 0) begin : g_src
            assign data_d = lookup;
            assign inv_d  = inv_sel;
        end else begin : g_xfer
            assign data_d = stage_data[gi-1];
            assign inv_d  = stage_inv[gi-1];
        end
        // Only the output stage is reset so Out_data/Out_inv read 0 after reset
        if (gi == STAGES - 1) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    inv_q  <= 1'b0;
                end else if (fill[gi]) begin
                    data_q <= data_d;
                    inv_q  <= inv_d;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (fill[gi]) begin
                    data_q <= data_d;
                    inv_q  <= inv_d;
                end
            end
        end
        assign stage_data[gi] = data_q;
        assign stage_inv[gi]  = inv_q;
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign out_data_o  = stage_data[STAGES-1];
    assign out_inv_o   = stage_inv[STAGES-1];
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_aes_sbox_array.sv
// Bench for aes_sbox_array: a 16-lane/2-stage and a 4-lane/3-stage instance against the FIPS-197 table.
module tb_aes_sbox_array;
    localparam int S16 = 2;
    localparam int S4  = 3;
`ifdef AES_SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid16, in_ready16, in_inv16, out_valid16, out_ready16, out_inv16;
    logic [127:0] in_data16, out_data16;
    logic [1:0]   occ16;
    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
    logic [31:0]  in_data4, out_data4;
    logic [1:0]   occ4;

    aes_sbox_array #(.LANES(16), .STAGES(S16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid16), .in_ready_o(in_ready16), .in_inv_i(in_inv16), .in_data_i(in_data16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready16), .out_inv_o(out_inv16),
        .out_data_o(out_data16), .occupancy_o(occ16)
    );

    aes_sbox_array #(.LANES(4), .STAGES(S4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_inv_i(in_inv4), .in_data_i(in_data4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4), .out_inv_o(out_inv4),
        .out_data_o(out_data4), .occupancy_o(occ4)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [2047:0] sbox_flat;
    logic [7:0]    sbox_t  [256];
    logic [7:0]    isbox_t [256];
    logic [128:0]  exp_q [$];
    logic [128:0]  mon_e;
    int            acc16 = 0;
    int            del16 = 0;
    bit            mon16_en = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = (INV_EN && inv) ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
        return r;
    endfunction

    // Scoreboard and occupancy tracker for the 16-lane instance
    always @(negedge clk) begin
        if (mon16_en) begin
            check("occ16", 128'(occ16), 128'(acc16 - del16));
            if (out_valid16 && out_ready16) begin
                if (exp_q.size() == 0) begin
                    check("spurious16", 128'(out_valid16), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data16", out_data16, mon_e[127:0]);
                    check("inv16", 128'(out_inv16), 128'(mon_e[128]));
                end
                del16++;
            end
            if (in_valid16 && in_ready16) begin
                exp_q.push_back({in_inv16 & INV_EN, model(in_data16, in_inv16)});
                acc16++;
            end
        end
    end

    task automatic drain16();
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || out_valid16); c++) @(posedge clk);
        @(negedge clk);
        check("drain16", 128'(exp_q.size()), 128'(0));
        check("empty16", 128'(occ16), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic lat16_test(input logic [127:0] d, input logic [127:0] e, input string tag);
        int lat;
        lat = 0;
        in_valid16  = 1'b1;
        in_inv16    = 1'b0;
        in_data16   = d;
        out_ready16 = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, 128'(in_ready16), 128'(1));
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid16) begin
                lat = c;
                check({tag, "_data"}, out_data16, e);
            end
        end
        check({tag, "_lat"}, 128'(lat), 128'(S16));
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        logic [127:0] held;
        sbox_flat = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                     128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                     128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                     128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                     128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                     128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                     128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                     128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[2047 - 8*i -: 8];
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

        in_valid16 = 1'b0; in_inv16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;
        in_valid4  = 1'b0; in_inv4  = 1'b0; in_data4  = '0; out_ready4  = 1'b1;

        // Reset state
        #3;
        check("rst_ovld16", 128'(out_valid16), 128'(0));
        check("rst_data16", out_data16, 128'(0));
        check("rst_inv16", 128'(out_inv16), 128'(0));
        check("rst_occ16", 128'(occ16), 128'(0));
        check("rst_ovld4", 128'(out_valid4), 128'(0));
        check("rst_data4", 128'(out_data4), 128'(0));
        check("rst_occ4", 128'(occ4), 128'(0));
        #9 rst_n = 1'b1;
        #1;
        check("rdy16_post_rst", 128'(in_ready16), 128'(1));
        check("rdy4_post_rst", 128'(in_ready4), 128'(1));
        mon16_en = 1'b1;
        @(posedge clk); #1;

        // SubWord on the 4-lane instance, then an inverse-mode beat back to back
        in_valid4 = 1'b1; in_inv4 = 1'b0; in_data4 = 32'hcf4f3c09;
        @(negedge clk); check("rdy4_a", 128'(in_ready4), 128'(1));
        @(posedge clk); #1;
        in_inv4 = 1'b1; in_data4 = 32'h7c16ed63;
        @(negedge clk); check("ovld4_c1", 128'(out_valid4), 128'(0));
        @(posedge clk); #1;
        in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = 32'hdeadbeef;
        @(negedge clk); check("ovld4_c2", 128'(out_valid4), 128'(0));
        @(negedge clk);
        check("ovld4_c3", 128'(out_valid4), 128'(1));
        check("subword4", 128'(out_data4), 128'(32'h8a84eb01));
        check("inv4_a", 128'(out_inv4), 128'(0));
        check("occ4_c3", 128'(occ4), 128'(2));
        @(negedge clk);
        check("ovld4_b", 128'(out_valid4), 128'(1));
        check("invdata4", 128'(out_data4), INV_EN ? 128'(32'h01ff5300) : 128'(32'h104755fb));
        check("inv4_b", 128'(out_inv4), 128'(INV_EN));
        @(negedge clk);
        check("ovld4_end", 128'(out_valid4), 128'(0));
        check("occ4_end", 128'(occ4), 128'(0));
        @(posedge clk); #1;

        // Forward hand vector on 16 lanes with latency measurement
        lat16_test(128'h8070605040302010093c4fcf01ff5300, 128'hcd51d0530904b7ca01eb848a7c16ed63, "vec16");

        // Full byte sweep, one beat per cycle
        for (int b = 0; b < 16; b++) begin
            in_valid16 = 1'b1; in_inv16 = 1'b0;
            for (int i = 0; i < 16; i++) in_data16[8*i +: 8] = 8'(16*b + i);
            @(negedge clk); check("rdy_sweep", 128'(in_ready16), 128'(1));
            @(posedge clk); #1;
        end
        drain16();

        // Alternating forward/inverse beats
        for (int b = 0; b < 8; b++) begin
            in_valid16 = 1'b1; in_inv16 = b[0];
            in_data16  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        drain16();

        // Backpressure with continuous input
        base = acc16;
        out_ready16 = 1'b0; in_valid16 = 1'b1; held = '0;
        for (int c = 0; c < 10; c++) begin
            in_data16 = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_inv16  = c[0];
            @(negedge clk);
            if (c == S16) held = out_data16;
            if (c >= S16) begin
                check("bp_rdy", 128'(in_ready16), 128'(0));
                check("bp_occ", 128'(occ16), 128'(S16));
                check("bp_ovld", 128'(out_valid16), 128'(1));
                check("bp_stable", out_data16, held);
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", 128'(acc16 - base), 128'(S16));
        drain16();

        // Random valid/ready traffic
        base = acc16;
        for (int c = 0; c < 60000 && (acc16 - base) < 10000; c++) begin
            in_valid16  = 1'($urandom_range(0, 1));
            in_inv16    = 1'($urandom_range(0, 1));
            in_data16   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready16 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("rand_beats", 128'((acc16 - base) >= 10000), 128'(1));
        drain16();

        // Reset in the middle of a stream
        in_valid16 = 1'b1; out_ready16 = 1'b1; in_inv16 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_data16 = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
        end
        @(negedge clk); check("pre_rst_occ", 128'(occ16), 128'(S16));
        @(posedge clk); #2;
        mon16_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovld16", 128'(out_valid16), 128'(0));
        check("mid_rst_occ16", 128'(occ16), 128'(0));
        check("mid_rst_data16", out_data16, 128'(0));
        in_valid16 = 1'b0;
        exp_q.delete();
        acc16 = 0;
        del16 = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        mon16_en = 1'b1;
        @(posedge clk); #1;
        lat16_test(128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, "post_rst");
        drain16();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
